mmu_ring: RTL and testbench

Capture-memory manager for the logic analyzer core, replacing the up/down-pointer scheme.
- Capture phase: samples are written continuously into an internal circular RAM of 2**DEPTH words. The oldest words are overwritten once the RAM is full.
- Readout phase: stored samples are streamed back newest-first, which is the order the host protocol expects, through a request/valid handshake.
- Sits between the sampler/trigger stage (write side) and the transmitter (read side).

---
 rtl/mmu_ring.sv | 128 ++++++++++++
 tb/tb_mmu_ring.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ring.sv
// rtl/mmu_ring.sv - circular capture memory, readout newest-first
module mmu_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             clr_i,
    input  logic             wrt_i,
    input  logic [WIDTH-1:0] mem_i,
    input  logic             rd_start_i,
    input  logic             rd_req_i,
    output logic [WIDTH-1:0] mem_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic [DEPTH:0]   count_o,
    output logic             done_o
);

    localparam int SIZE = 1 << DEPTH;
    localparam logic [DEPTH:0] FULL_COUNT = (DEPTH+1)'(SIZE);

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_READOUT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] ram [0:SIZE-1];
    logic [DEPTH-1:0] wr_ptr_q;
    logic [DEPTH-1:0] rd_ptr_q;
    logic [DEPTH:0]   count_q;
    logic [DEPTH:0]   remaining_q;
    logic [DEPTH:0]   count_wr;
    logic             wr_en;
    logic             rd_en;
    logic             start_rd;

    // Writes only land while capturing and never alongside a restart.
    assign wr_en    = rst_in && !clr_i && (state_q == ST_CAPTURE) && wrt_i;
    assign count_wr = (wr_en && (count_q != FULL_COUNT)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        start_rd = 1'b0;
        if (clr_i) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (rd_start_i) begin
                        start_rd = 1'b1;
                        state_d  = (count_wr == '0) ? ST_DONE : ST_READOUT;
                    end
                end
                ST_READOUT: begin
                    if (rd_req_i && (remaining_q != '0)) begin
                        rd_en = 1'b1;
                        if (remaining_q == (DEPTH+1)'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_CAPTURE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ram[wr_ptr_q] <= mem_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            mem_o       <= '0;
            rd_valid_o  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            rd_valid_o  <= 1'b0;
        end else begin
            rd_valid_o <= rd_en;
            count_q    <= count_wr;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            // A same-cycle write is the newest sample, so readout starts on it.
            if (start_rd) begin
                rd_ptr_q    <= wr_en ? wr_ptr_q : wr_ptr_q - 1'b1;
                remaining_q <= count_wr;
            end
            if (rd_en) begin
                mem_o       <= ram[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q - 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mmu_ring.sv
// tb/tb_mmu_ring.sv - scoreboard bench for mmu_ring
module tb_mmu_ring;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    logic             clk_i = 1'b0;
    logic             rst_in;
    logic             clr_i;
    logic             wrt_i;
    logic [WIDTH-1:0] mem_i;
    logic             rd_start_i;
    logic             rd_req_i;
    logic [WIDTH-1:0] mem_o;
    logic             rd_valid_o;
    logic             full_o;
    logic [DEPTH:0]   count_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [$];

    mmu_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .clr_i      (clr_i),
        .wrt_i      (wrt_i),
        .mem_i      (mem_i),
        .rd_start_i (rd_start_i),
        .rd_req_i   (rd_req_i),
        .mem_o      (mem_o),
        .rd_valid_o (rd_valid_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rd_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_data: unexpected rd_valid_o with mem_o=%h, nothing expected", mem_o);
            end else begin
                automatic logic [WIDTH-1:0] e = exp_q.pop_front();
                if (mem_o !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %h expected %h", mem_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] v);
        wrt_i = 1'b1;
        mem_i = v;
        tick();
        wrt_i = 1'b0;
    endtask

    task automatic start();
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
    endtask

    task automatic clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic req(input bit expect_valid, input logic [WIDTH-1:0] v);
        if (expect_valid) exp_q.push_back(v);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_in = 1'b0; clr_i = 1'b0; wrt_i = 1'b0; mem_i = '0;
        rd_start_i = 1'b0; rd_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_mem_o", 64'(mem_o), 64'd0);
        rst_in = 1'b1;
        tick();

        // 1: three samples read back newest-first
        wr(32'h11); wr(32'h22); wr(32'h33);
        check("t1_count", 64'(count_o), 64'd3);
        check("t1_full", 64'(full_o), 64'd0);
        start();
        check("t1_done_early", 64'(done_o), 64'd0);
        req(1, 32'h33); req(1, 32'h22); req(1, 32'h11);
        check("t1_done", 64'(done_o), 64'd1);
        drain("t1_drain");

        // 2: 40 writes wrap; last 32 returned, rd_ptr wraps 0 -> 31
        clr();
        for (int i = 0; i < 40; i++) wr(32'(i));
        check("t2_full", 64'(full_o), 64'd1);
        check("t2_count", 64'(count_o), 64'd32);
        start();
        for (int i = 0; i < 32; i++) req(1, 32'(39 - i));
        check("t2_done", 64'(done_o), 64'd1);
        drain("t2_drain");

        // 3: 33 back-to-back requests on a full buffer
        clr();
        for (int i = 0; i < 32; i++) wr(32'h100 + 32'(i));
        start();
        for (int i = 0; i < 32; i++) req(1, 32'h100 + 32'(31 - i));
        req(0, '0);
        check("t3_done", 64'(done_o), 64'd1);
        check("t3_count_hold", 64'(count_o), 64'd32);
        drain("t3_drain");

        // 4: start on empty buffer, then write together with start
        clr();
        start();
        check("t4_done_empty", 64'(done_o), 64'd1);
        check("t4_count_empty", 64'(count_o), 64'd0);
        req(0, '0); req(0, '0);
        drain("t4_drain_empty");
        clr();
        wrt_i = 1'b1; mem_i = 32'hABC; rd_start_i = 1'b1;
        tick();
        wrt_i = 1'b0; rd_start_i = 1'b0;
        check("t4_count_one", 64'(count_o), 64'd1);
        check("t4_not_done", 64'(done_o), 64'd0);
        req(1, 32'hABC);
        check("t4_done_one", 64'(done_o), 64'd1);
        drain("t4_drain_one");

        // 5: writes ignored in readout, clr mid-readout, clr drops a write
        clr();
        wr(32'hA1); wr(32'hA2); wr(32'hA3);
        start();
        req(1, 32'hA3);
        wr(32'hDEAD);
        check("t5_count_hold", 64'(count_o), 64'd3);
        req(1, 32'hA2);
        drain("t5_drain_a");
        clr_i = 1'b1; wrt_i = 1'b1; mem_i = 32'hBAD;
        tick();
        clr_i = 1'b0; wrt_i = 1'b0;
        check("t5_clr_count", 64'(count_o), 64'd0);
        check("t5_clr_done", 64'(done_o), 64'd0);
        wr(32'h5);
        check("t5_count_new", 64'(count_o), 64'd1);
        start();
        req(1, 32'h5);
        check("t5_done", 64'(done_o), 64'd1);
        drain("t5_drain_b");

        // 6: asynchronous reset mid-readout and in DONE
        clr();
        wr(32'h1); wr(32'h2); wr(32'h3);
        start();
        req(0, '0);
        #1 rst_in = 1'b0;
        #1;
        check("t6_valid_async", 64'(rd_valid_o), 64'd0);
        check("t6_count_async", 64'(count_o), 64'd0);
        check("t6_done_async", 64'(done_o), 64'd0);
        check("t6_mem_async", 64'(mem_o), 64'd0);
        tick();
        rst_in = 1'b1;
        tick();
        wr(32'h77);
        check("t6_count_after", 64'(count_o), 64'd1);
        start();
        req(1, 32'h77);
        check("t6_done_after", 64'(done_o), 64'd1);
        drain("t6_drain");
        #2 rst_in = 1'b0;
        #1;
        check("t6_done_reset", 64'(done_o), 64'd0);
        tick();
        rst_in = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
